// File: rtl/axi_lite_pkg.sv
// =============================================================================
// axi_lite_pkg: AXI-Lite response codes and master FSM state encoding. Rev 1.0
// =============================================================================
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master_stats.sv
// =============================================================================
// axi_lite_master_stats: saturating write/read/error counters for the master. Rev 1.0
// =============================================================================
`default_nettype none

module axi_lite_master_stats
  import axi_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we,
  input  logic [1:0]  resp,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_errors
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_writes <= '0;
      stat_reads  <= '0;
      stat_errors <= '0;
    end else if (inc) begin
      if (we) stat_writes <= sat_inc(stat_writes);
      else    stat_reads  <= sat_inc(stat_reads);
      if (resp != OKAY) stat_errors <= sat_inc(stat_errors);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_master.sv
// =============================================================================
// axi_lite_master: single-outstanding command-to-AXI4-Lite bridge; defining
// AXI_LITE_MASTER_STATS_EN adds transaction/error counters. Rev 1.0
// =============================================================================
`default_nettype none

module axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_we,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
`ifdef AXI_LITE_MASTER_STATS_EN
  ,
  output logic [15:0]                 stat_writes,
  output logic [15:0]                 stat_reads,
  output logic [15:0]                 stat_errors
`endif
);
  import axi_lite_pkg::*;

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  state_t                      state, state_next;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        we_q;
  logic                        aw_pend, w_pend;
  logic                        aw_done, w_done;

  // A channel counts as done once its handshake has happened or is happening now.
  assign aw_done = !aw_pend || axi_awready;
  assign w_done  = !w_pend  || axi_wready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid)         state_next = cmd_we ? WRITE : RADDR;
      WRITE:   if (aw_done && w_done) state_next = WRESP;
      WRESP:   if (axi_bvalid)        state_next = RSP;
      RADDR:   if (axi_arready)       state_next = RDATA;
      RDATA:   if (axi_rvalid)        state_next = RSP;
      RSP:     if (rsp_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        we_q    <= cmd_we;
        aw_pend <= cmd_we;
        w_pend  <= cmd_we;
      end
      if (state == WRITE) begin
        if (axi_awready) aw_pend <= 1'b0;
        if (axi_wready)  w_pend  <= 1'b0;
      end
      if (state == WRESP && axi_bvalid) begin
        rsp_rdata <= '0;
        rsp_resp  <= axi_bresp;
      end
      if (state == RDATA && axi_rvalid) begin
        rsp_rdata <= axi_rdata;
        rsp_resp  <= axi_rresp;
      end
    end
  end

  // Gating with reset keeps cmd_ready low while reset is held.
  assign cmd_ready   = (state == IDLE) && !axi_reset;
  assign rsp_valid   = (state == RSP);
  assign rsp_we      = we_q;
  assign axi_awaddr  = addr_q;
  assign axi_awvalid = aw_pend;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = {STRB_W{w_pend}};
  assign axi_wvalid  = w_pend;
  assign axi_bready  = (state == WRESP);
  assign axi_araddr  = addr_q;
  assign axi_arvalid = (state == RADDR);
  assign axi_rready  = (state == RDATA);

`ifdef AXI_LITE_MASTER_STATS_EN
  logic       stat_inc;
  logic [1:0] stat_resp;

  assign stat_inc  = (state != RSP) && (state_next == RSP);
  assign stat_resp = (state == WRESP) ? axi_bresp : axi_rresp;

  axi_lite_master_stats u_stats (
    .clk         (axi_clk),
    .rst         (axi_reset),
    .inc         (stat_inc),
    .we          (we_q),
    .resp        (stat_resp),
    .stat_writes (stat_writes),
    .stat_reads  (stat_reads),
    .stat_errors (stat_errors)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// =============================================================================
// tb_axi_lite_master: scoreboard bench with a behavioural AXI-Lite memory slave. Rev 1.0
// =============================================================================
`default_nettype none

module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic       clk = 1'b0;
  logic       axi_reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_we;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [9:0] axi_awaddr, axi_araddr;
  logic       axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
  logic [7:0] axi_wdata;
  logic [0:0] axi_wstrb;
  logic       axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic       axi_arready = 1'b0, axi_rvalid = 1'b0;
  logic [1:0] axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic [7:0] axi_rdata = '0;
`ifdef AXI_LITE_MASTER_STATS_EN
  logic [15:0] stat_writes, stat_reads, stat_errors;
`endif

  axi_lite_master #(.AXI_ADDR_WIDTH(10), .AXI_DATA_WIDTH(8)) dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
`ifdef AXI_LITE_MASTER_STATS_EN
    , .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         we;
    logic [7:0] rdata;
    logic [1:0] resp;
    int         acc;
    bit         zw;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] slave_resp_q[$];
  logic [7:0] ref_mem[1024];
  logic [7:0] slave_mem[1024];
  int total = 0, bad = 0;
  int m_w = 0, m_r = 0, m_e = 0, n_wr = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int slave_mode = 0;  // 0 zero-wait, 1 random, 2 wready three cycles ahead of awready
  int rsp_mode = 0;    // 0 always ready, 1 random, 2 hold off for ten cycles
  bit hold_r = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural AXI-Lite slave backed by slave_mem.
  initial begin
    bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit got_aw = 0, got_w = 0, got_ar = 0;
    logic [9:0] s_awaddr = '0, s_araddr = '0;
    logic [7:0] s_wdata = '0;
    int since_w = 0;
    forever begin
      @(negedge clk);
      if (axi_reset) begin
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar} = '0;
        axi_bvalid = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_arready = 0;
        continue;
      end
      if (got_w) since_w++;
      if (aw_hs) got_aw = 1;
      if (w_hs) begin got_w = 1; since_w = 0; end
      if (ar_hs) got_ar = 1;
      if (b_hs) axi_bvalid = 0;
      if (r_hs) axi_rvalid = 0;
      if (got_aw && got_w && !axi_bvalid && (slave_mode != 1 || $urandom_range(0, 1) == 1)) begin
        slave_mem[s_awaddr] = s_wdata;
        axi_bresp = (slave_resp_q.size() > 0) ? slave_resp_q.pop_front() : 2'b00;
        axi_bvalid = 1; got_aw = 0; got_w = 0;
      end
      if (got_ar && !axi_rvalid && !hold_r && (slave_mode != 1 || $urandom_range(0, 1) == 1)) begin
        axi_rdata = slave_mem[s_araddr];
        axi_rresp = (slave_resp_q.size() > 0) ? slave_resp_q.pop_front() : 2'b00;
        axi_rvalid = 1; got_ar = 0;
      end
      case (slave_mode)
        1: begin
          axi_awready = 1'($urandom_range(0, 1)); axi_wready = 1'($urandom_range(0, 1));
          axi_arready = 1'($urandom_range(0, 1));
        end
        2: begin
          axi_wready = 1; axi_awready = got_w && since_w >= 2; axi_arready = 1;
        end
        default: begin
          axi_awready = 1; axi_wready = 1; axi_arready = 1;
        end
      endcase
      aw_hs = axi_awvalid && axi_awready; if (aw_hs) s_awaddr = axi_awaddr;
      w_hs  = axi_wvalid && axi_wready;   if (w_hs) s_wdata = axi_wdata;
      ar_hs = axi_arvalid && axi_arready; if (ar_hs) s_araddr = axi_araddr;
      b_hs  = axi_bvalid && axi_bready;
      r_hs  = axi_rvalid && axi_rready;
    end
  end

  initial begin
    int hold_cnt = 0;
    forever begin
      @(negedge clk);
      hold_cnt = rsp_valid ? hold_cnt + 1 : 0;
      case (rsp_mode)
        1:       rsp_ready = 1'($urandom_range(0, 1));
        2:       rsp_ready = (hold_cnt > 10);
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: protocol checks plus scoreboard pop on each new response.
  initial begin
    bit have_prev = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic p_bv = 0, p_br = 0, p_rv = 0, p_rr = 0;
    logic [9:0] p_awaddr = '0, p_araddr = '0;
    logic [7:0] p_wdata = '0, p_rdata = '0;
    logic [1:0] p_resp = '0;
    logic p_we = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (axi_reset) begin have_prev = 0; continue; end
      if (have_prev) begin
        if (p_awv && !p_awr) check(axi_awvalid && axi_awaddr == p_awaddr, "aw_hold", {axi_awvalid, axi_awaddr}, {1'b1, p_awaddr});
        if (p_awv && p_awr) begin aw_cnt++; check(!axi_awvalid, "aw_drop", axi_awvalid, 0); end
        if (p_wv && !p_wr) check(axi_wvalid && axi_wdata == p_wdata, "w_hold", {axi_wvalid, axi_wdata}, {1'b1, p_wdata});
        if (p_wv && p_wr) begin w_cnt++; check(!axi_wvalid, "w_drop", axi_wvalid, 0); end
        if (p_arv && !p_arr) check(axi_arvalid && axi_araddr == p_araddr, "ar_hold", {axi_arvalid, axi_araddr}, {1'b1, p_araddr});
        if (p_bv && p_br) b_cnt++;
        if (p_rv && !p_rr) check(rsp_valid && rsp_rdata == p_rdata && rsp_resp == p_resp && rsp_we == p_we,
                                 "rsp_hold", {rsp_valid, rsp_we, rsp_resp, rsp_rdata}, {1'b1, p_we, p_resp, p_rdata});
        if (p_rv && p_rr) check(cmd_ready, "idle_after_rsp", cmd_ready, 1);
      end
      if (axi_wvalid) check(axi_wstrb == 1'b1, "wstrb", axi_wstrb, 1);
      if (rsp_valid) check(!cmd_ready && !axi_awvalid && !axi_arvalid && !axi_wvalid, "rsp_quiet",
                           {cmd_ready, axi_awvalid, axi_arvalid, axi_wvalid}, 0);
      if (rsp_valid && !(have_prev && p_rv)) begin
        if (exp_q.size() == 0) check(0, "unexpected_rsp", rsp_rdata, 0);
        else begin
          e = exp_q.pop_front();
          check(rsp_we == e.we, "rsp_we", rsp_we, e.we);
          check(rsp_rdata == e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
          check(rsp_resp == e.resp, "rsp_resp", rsp_resp, e.resp);
          if (e.zw) check(cyc - e.acc == 3, "latency", cyc - e.acc, 3);
          else      check(cyc - e.acc >= 3, "latency_min", cyc - e.acc, 3);
          if (e.we) m_w++; else m_r++;
          if (e.resp != OKAY) m_e++;
        end
      end
      have_prev = 1;
      p_awv = axi_awvalid; p_awr = axi_awready; p_awaddr = axi_awaddr;
      p_wv = axi_wvalid; p_wr = axi_wready; p_wdata = axi_wdata;
      p_arv = axi_arvalid; p_arr = axi_arready; p_araddr = axi_araddr;
      p_bv = axi_bvalid; p_br = axi_bready;
      p_rv = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_rdata; p_resp = rsp_resp; p_we = rsp_we;
    end
  end

  task automatic do_cmd(input bit we, input logic [9:0] addr, input logic [7:0] data, input logic [1:0] resp);
    exp_t e;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data;
    forever begin
      #1;
      if (cmd_ready) break;
      n++;
      if (n > 1000) begin
        check(0, "cmd_accept_timeout", 0, 1);
        cmd_valid = 0;
        return;
      end
      @(negedge clk);
    end
    e.we = we; e.resp = resp; e.acc = cyc; e.zw = (slave_mode == 0);
    if (we) begin ref_mem[addr] = data; e.rdata = 8'h00; n_wr++; end
    else e.rdata = ref_mem[addr];
    exp_q.push_back(e);
    slave_resp_q.push_back(resp);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

`ifdef AXI_LITE_MASTER_STATS_EN
  task automatic check_stats();
    check(stat_writes == 16'(m_w), "stat_writes", stat_writes, m_w);
    check(stat_reads == 16'(m_r), "stat_reads", stat_reads, m_r);
    check(stat_errors == 16'(m_e), "stat_errors", stat_errors, m_e);
  endtask
`endif

  initial begin
    logic [1:0] r;
    int n;
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = 8'h00; slave_mem[i] = 8'h00; end
    repeat (3) @(negedge clk);
    #1;
    check({cmd_ready, rsp_valid, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready} == 0,
          "reset_outputs", {cmd_ready, rsp_valid, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
    @(negedge clk);
    axi_reset = 0;
    #1;
    check(cmd_ready, "ready_after_reset", cmd_ready, 1);

    slave_mode = 0; rsp_mode = 0;
    do_cmd(1, 10'h0B0, 8'h10, OKAY);
    do_cmd(1, 10'h0E0, 8'h40, OKAY);
    do_cmd(0, 10'h0E0, 8'h00, OKAY);
    for (int i = 0; i < 3; i++) begin
      do_cmd(1, 10'(10'h0D0 + i), 8'(8'h50 + i), OKAY);
      do_cmd(0, 10'(10'h0D0 + i), 8'h00, OKAY);
    end
    for (int i = 0; i < 3; i++) do_cmd(0, 10'(10'h0D0 + i), 8'h00, OKAY);
    drain();

    rsp_mode = 2;
    do_cmd(0, 10'h0B0, 8'h00, OKAY);
    do_cmd(1, 10'h0B1, 8'h77, DECERR);
    drain();

    slave_mode = 2; rsp_mode = 0;
    do_cmd(1, 10'h120, 8'h5A, OKAY);
    do_cmd(0, 10'h120, 8'h00, OKAY);
    drain();

    slave_mode = 1; rsp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : OKAY;
      do_cmd(1'($urandom_range(0, 1)), 10'(10'h100 + $urandom_range(0, 15)), 8'($urandom), r);
    end
    drain();
`ifdef AXI_LITE_MASTER_STATS_EN
    check_stats();
`endif
    check(aw_cnt == n_wr, "aw_count", aw_cnt, n_wr);
    check(w_cnt == n_wr, "w_count", w_cnt, n_wr);
    check(b_cnt == n_wr, "b_count", b_cnt, n_wr);

    // Reset while the read sits waiting for rvalid.
    slave_mode = 0; rsp_mode = 0; hold_r = 1;
    do_cmd(0, 10'h0E0, 8'h00, OKAY);
    n = 0;
    while (!axi_rready && n < 100) begin @(negedge clk); #1; n++; end
    check(axi_rready, "reach_rdata", axi_rready, 1);
    #2;
    axi_reset = 1;
    #1;
    check({cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp, axi_awaddr, axi_awvalid, axi_wdata,
           axi_wstrb, axi_wvalid, axi_bready, axi_araddr, axi_arvalid, axi_rready} == 0, "async_reset_outputs",
          {axi_araddr, axi_rready, axi_arvalid, cmd_ready}, 0);
    exp_q.delete(); slave_resp_q.delete();
    m_w = 0; m_r = 0; m_e = 0;
    hold_r = 0;
    repeat (2) @(negedge clk);
    axi_reset = 0;
    #1;
    check(cmd_ready, "ready_after_midreset", cmd_ready, 1);
`ifdef AXI_LITE_MASTER_STATS_EN
    check_stats();
`endif

    do_cmd(0, 10'h150, 8'h00, SLVERR);
    drain();
`ifdef AXI_LITE_MASTER_STATS_EN
    check(stat_errors == 16'd1, "stat_errors_one", stat_errors, 1);
    check(stat_reads == 16'd1, "stat_reads_one", stat_reads, 1);
`endif
    do_cmd(0, 10'h0E0, 8'h00, OKAY);
    drain();
`ifdef AXI_LITE_MASTER_STATS_EN
    check_stats();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
